sys_trap_ctrl: RTL
==================

// Module: sys_trap_ctrl
// PURPOSE
//  Multi-cycle sequencer for trap entry (ecall) and trap return (mret).
//  Sits after the decoder. Takes the system-instruction flags and the current PC.
//  Drives the single CSR-file port through read-modify-write steps, then issues a
//  one-cycle PC redirect to the PC unit. Stalls fetch/decode while a sequence runs.
// PARAMETERS
//  XLEN          64      datapath / CSR data width
//  CSR_AW        12      CSR address width
//  ECALL_CAUSE   11      mcause value written on ecall (M-mode environment call)
// PORTS
//  i_clk          in   1       clock, rising edge
//  i_rst          in   1       synchronous reset, active-high
//  i_valid        in   1       decoded instruction valid this cycle
//  o_ready        out  1       block can accept an instruction (state IDLE)
//  i_ecall        in   1       decoder ecall flag (qualified by i_valid)
//  i_mret         in   1       decoder mret flag (qualified by i_valid)
//  i_pc           in   XLEN    PC of the presented instruction
//  o_csr_addr     out  CSR_AW  CSR-file read/write address
//  i_csr_rdata    in   XLEN    CSR-file combinational read data for o_csr_addr
//  o_csr_wen      out  1       CSR-file write enable, applied at next rising edge
//  o_csr_wdata    out  XLEN    CSR-file write data
//  o_busy         out  1       stall to IFU/IDU; high in every non-IDLE state
//  o_redir_valid  out  1       one-cycle PC redirect pulse
//  o_redir_pc     out  XLEN    redirect target; valid only with o_redir_valid
// BEHAVIOUR
//  CSR addrs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
//  Reset: state=IDLE. Latched PC cleared to 0.
//    All outputs are 0, except o_ready=1 in IDLE.
//  States: IDLE, EC_EPC, EC_CAUSE, EC_STAT, EC_VEC, MR_STAT, MR_EPC.
//  IDLE: o_ready=1, o_busy=0, o_csr_wen=0, o_redir_valid=0, o_csr_addr=0.
//    i_valid & i_ecall: latch i_pc, go to EC_EPC.
//    i_valid & i_mret & !i_ecall: go to MR_STAT.
//    Both flags set: ecall wins.
//    i_valid with neither flag, or !i_valid: stay in IDLE.
//  EC_EPC: addr=mepc, wen=1, wdata=latched PC. Next state: EC_CAUSE.
//  EC_CAUSE: addr=mcause, wen=1, wdata=ECALL_CAUSE zero-extended to XLEN.
//    Next state: EC_STAT.
//  EC_STAT: addr=mstatus, wen=1, wdata = rdata with:
//    MPIE[7]  <= MIE[3]
//    MIE[3]   <= 0
//    MPP[12:11] <= 2'b11
//    All other bits unchanged. Next state: EC_VEC.
//  EC_VEC: addr=mtvec, wen=0.
//    o_redir_valid=1, o_redir_pc = rdata & ~XLEN'h3 (direct mode only).
//    Next state: IDLE.
//  MR_STAT: addr=mstatus, wen=1, wdata = rdata with:
//    MIE[3]  <= MPIE[7]
//    MPIE[7] <= 1
//    MPP[12:11] <= 2'b11
//    Next state: MR_EPC.
//  MR_EPC: addr=mepc, wen=0.
//    o_redir_valid=1, o_redir_pc = rdata & ~XLEN'h3.
//    Next state: IDLE.
//  Latency from accept edge to redirect: ecall = 4 cycles, mret = 2 cycles.
//    o_busy is high exactly those cycles.
//    o_ready is high in IDLE only, so a new instruction is accepted the cycle
//    after the redirect.
//  While busy: i_valid, i_ecall, i_mret and i_pc are ignored.
//    The latched PC is held.
//  o_redir_valid is a single-cycle pulse, never held. There is no redirect ack;
//    the PC unit must take it that cycle.
//  Reset in any state: next cycle IDLE, outputs at reset values.
//    No partial CSR write occurs on the reset edge (wen forced 0 while i_rst=1).
//  No combinational path from i_valid/i_ecall/i_mret to any output.
//    Everything except i_csr_rdata-derived data is decoded from state.
// TESTING
//  1. Reset hold, then release -> o_ready=1, o_busy=0, wen=0, redir=0;
//     i_valid with no flags -> stays in IDLE.
//  2. ecall at pc=0x8000_0010, mtvec=0x8000_0103, mstatus=0x8 ->
//     mepc=0x8000_0010, mcause=11, mstatus=0x1880;
//     redirect to 0x8000_0100 four cycles after accept.
//  3. mret with mepc=0x8000_0014, mstatus=0x1880 -> mstatus=0x1888;
//     redirect to 0x8000_0014 two cycles after accept.
//  4. i_ecall=i_mret=1 together -> ecall sequence.
//     i_valid+ecall pulses while busy -> ignored; mepc keeps the first PC.
//  5. i_rst asserted in EC_CAUSE -> no mcause write on that edge;
//     IDLE next cycle; no redirect pulse.
//  6. Back-to-back ecall then mret (mret presented the cycle after redirect) ->
//     accepted immediately; redirect to the mepc written by the ecall.

Source files
------------

// File: rtl/sys_trap_ctrl.sv
// Trap entry (ecall) / trap return (mret) sequencer: drives the CSR port through
// read-modify-write steps, then pulses a PC redirect while stalling fetch/decode.
module sys_trap_ctrl #(
   parameter int XLEN        = 64,
   parameter int CSR_AW      = 12,
   parameter int ECALL_CAUSE = 11
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_ecall,
   input  logic              i_mret,
   input  logic [XLEN-1:0]   i_pc,
   output logic [CSR_AW-1:0] o_csr_addr,
   input  logic [XLEN-1:0]   i_csr_rdata,
   output logic              o_csr_wen,
   output logic [XLEN-1:0]   o_csr_wdata,
   output logic              o_busy,
   output logic              o_redir_valid,
   output logic [XLEN-1:0]   o_redir_pc
);

   localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
   localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(12'h305);
   localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
   localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);
   localparam logic [XLEN-1:0]   CAUSE_VAL  = XLEN'(ECALL_CAUSE);
   localparam logic [XLEN-1:0]   ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   typedef enum logic [2:0] {
      IDLE, EC_EPC, EC_CAUSE, EC_STAT, EC_VEC, MR_STAT, MR_EPC
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [XLEN-1:0]   pc_lat;

   // Trap entry: stack MIE into MPIE, disable interrupts, previous mode = M.
   function automatic logic [XLEN-1:0] ecall_mstatus(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] r;
      r        = s;
      r[7]     = s[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   // Trap return: restore MIE from MPIE, set MPIE, MPP stays M (M-only hart).
   function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] r;
      r        = s;
      r[3]     = s[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b11;
      return r;
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         pc_lat <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && i_valid && i_ecall)
            pc_lat <= i_pc;
      end
   end

   always_comb begin
      state_nxt     = state;
      o_ready       = 1'b0;
      o_busy        = 1'b1;
      o_csr_addr    = '0;
      o_csr_wen     = 1'b0;
      o_csr_wdata   = '0;
      o_redir_valid = 1'b0;
      o_redir_pc    = '0;
      case (state)
         IDLE: begin
            o_ready = 1'b1;
            o_busy  = 1'b0;
            if (i_valid && i_ecall)
               state_nxt = EC_EPC;
            else if (i_valid && i_mret)
               state_nxt = MR_STAT;
         end
         EC_EPC: begin
            o_csr_addr  = A_MEPC;
            o_csr_wen   = 1'b1;
            o_csr_wdata = pc_lat;
            state_nxt   = EC_CAUSE;
         end
         EC_CAUSE: begin
            o_csr_addr  = A_MCAUSE;
            o_csr_wen   = 1'b1;
            o_csr_wdata = CAUSE_VAL;
            state_nxt   = EC_STAT;
         end
         EC_STAT: begin
            o_csr_addr  = A_MSTATUS;
            o_csr_wen   = 1'b1;
            o_csr_wdata = ecall_mstatus(i_csr_rdata);
            state_nxt   = EC_VEC;
         end
         EC_VEC: begin
            o_csr_addr    = A_MTVEC;
            o_redir_valid = 1'b1;
            o_redir_pc    = i_csr_rdata & ALIGN_MASK;
            state_nxt     = IDLE;
         end
         MR_STAT: begin
            o_csr_addr  = A_MSTATUS;
            o_csr_wen   = 1'b1;
            o_csr_wdata = mret_mstatus(i_csr_rdata);
            state_nxt   = MR_EPC;
         end
         MR_EPC: begin
            o_csr_addr    = A_MEPC;
            o_redir_valid = 1'b1;
            o_redir_pc    = i_csr_rdata & ALIGN_MASK;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A reset edge must never commit a half-finished sequence.
      if (i_rst) begin
         o_csr_wen     = 1'b0;
         o_redir_valid = 1'b0;
      end
   end

endmodule
